// File: rtl/cp0_pkg.sv
// ============================================================================
// Module      : cp0_pkg
// Description : Shared CP0 register addresses, field positions, ExcCode values
//               and register field types.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cp0_pkg;

    localparam logic [4:0] c_addr_sr    = 5'd12;
    localparam logic [4:0] c_addr_cause = 5'd13;
    localparam logic [4:0] c_addr_epc   = 5'd14;
    localparam logic [4:0] c_addr_prid  = 5'd15;

    localparam int c_sr_ie_bit    = 0;
    localparam int c_sr_exl_bit   = 1;
    localparam int c_im_lo        = 10;
    localparam int c_im_hi        = 15;
    localparam int c_cause_bd_bit = 31;
    localparam int c_exc_lo       = 2;
    localparam int c_exc_hi       = 6;

    typedef enum logic [4:0] {
        EXC_INT     = 5'd0,
        EXC_ADEL    = 5'd4,
        EXC_ADES    = 5'd5,
        EXC_SYSCALL = 5'd8,
        EXC_RI      = 5'd10,
        EXC_OV      = 5'd12
    } exc_code_e;

    typedef struct packed {
        logic [5:0] im;
        logic       exl;
        logic       ie;
    } sr_t;

    typedef struct packed {
        logic       bd;
        logic [5:0] ip;
        logic [4:0] exc_code;
    } cause_t;

    function automatic logic [31:0] sr_word(input sr_t s);
        logic [31:0] w;
        w                    = '0;
        w[c_im_hi:c_im_lo]   = s.im;
        w[c_sr_exl_bit]      = s.exl;
        w[c_sr_ie_bit]       = s.ie;
        return w;
    endfunction

    function automatic logic [31:0] cause_word(input cause_t c);
        logic [31:0] w;
        w                      = '0;
        w[c_cause_bd_bit]      = c.bd;
        w[c_im_hi:c_im_lo]     = c.ip;
        w[c_exc_hi:c_exc_lo]   = c.exc_code;
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cp0_req.sv
// ============================================================================
// Module      : cp0_req
// Description : Combinational interrupt / exception request evaluation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cp0_req
    import cp0_pkg::*;
(
    input  logic [5:0] i_hw_int,
    input  logic [5:0] i_im,
    input  logic       i_ie,
    input  logic       i_exl,
    input  logic [4:0] i_exc_code,
    output logic       o_int_req,
    output logic       o_exc_req,
    output logic       o_req
);

    assign o_int_req = (|(i_hw_int & i_im)) & i_ie & ~i_exl;
    assign o_exc_req = (i_exc_code != EXC_INT) & ~i_exl;
    assign o_req     = o_int_req | o_exc_req;

endmodule

`default_nettype wire

// File: rtl/cp0.sv
// ============================================================================
// Module      : cp0
// Description : Coprocessor 0 - SR, Cause, EPC, PRId and exception entry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cp0
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID = 32'h0000_0007
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [4:0]  CP0Addr,
    input  logic [31:0] CP0In,
    input  logic [31:0] VPC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic [31:0] CP0Out,
    output logic [31:0] EPCOut,
    output logic        Req
);

    sr_t         r_sr;
    cause_t      r_cause;
    logic [31:0] r_epc;

    logic        w_int_req;
    logic        w_exc_req;
    logic        w_req;
    logic        w_wr_sr;
    logic        w_wr_epc;
    logic [31:0] w_rd;

    cp0_req u_req (
        .i_hw_int   (HWInt),
        .i_im       (r_sr.im),
        .i_ie       (r_sr.ie),
        .i_exl      (r_sr.exl),
        .i_exc_code (ExcCodeIn),
        .o_int_req  (w_int_req),
        .o_exc_req  (w_exc_req),
        .o_req      (w_req)
    );

    assign w_wr_sr  = en && (CP0Addr == c_addr_sr);
    assign w_wr_epc = en && (CP0Addr == c_addr_epc);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sr    <= '0;
            r_cause <= '0;
            r_epc   <= '0;
        end else begin
            r_cause.ip <= HWInt;
            if (w_req) begin
                r_sr.exl         <= 1'b1;
                // Interrupt wins when both are pending, reported as ExcCode 0.
                r_cause.exc_code <= (w_exc_req && !w_int_req) ? ExcCodeIn : EXC_INT;
                r_cause.bd       <= BDIn;
                r_epc            <= BDIn ? (VPC - 32'd4) : VPC;
            end else begin
                if (w_wr_sr) begin
                    r_sr.im <= CP0In[c_im_hi:c_im_lo];
                    r_sr.ie <= CP0In[c_sr_ie_bit];
                end
                // eret clears EXL after any same-cycle SR write lands.
                if (EXLClr) begin
                    r_sr.exl <= 1'b0;
                end else if (w_wr_sr) begin
                    r_sr.exl <= CP0In[c_sr_exl_bit];
                end
                if (w_wr_epc) begin
                    r_epc <= CP0In;
                end
            end
        end
    end

    always_comb begin
        w_rd = '0;
        case (CP0Addr)
            c_addr_sr:    w_rd = sr_word(r_sr);
            c_addr_cause: w_rd = cause_word(r_cause);
            c_addr_epc:   w_rd = r_epc;
            c_addr_prid:  w_rd = PRID;
            default:      w_rd = '0;
        endcase
    end

    assign CP0Out = w_rd;
    assign EPCOut = r_epc;
    assign Req    = w_req;

endmodule

`default_nettype wire

// File: tb/tb_cp0.sv
// ============================================================================
// Module      : tb_cp0
// Description : Self-checking bench for cp0: directed vector table, hand
//               sequences and randomized cycles against a word-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cp0;

    typedef struct {
        logic        rst_n;
        logic        en;
        logic [4:0]  addr;
        logic [31:0] din;
        logic [31:0] vpc;
        logic        bd;
        logic [4:0]  exc;
        logic [5:0]  hw;
        logic        exlclr;
    } in_t;

    typedef struct {
        in_t         i;
        logic        req;
        logic [31:0] sr;
        logic [31:0] cause;
        logic [31:0] epc;
    } vec_t;

    localparam logic [31:0] c_prid   = 32'h0000_0007;
    localparam int          c_nvec   = 15;
    localparam int          c_nrand  = 600;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [4:0]  CP0Addr;
    logic [31:0] CP0In;
    logic [31:0] VPC;
    logic        BDIn;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic [31:0] CP0Out;
    logic [31:0] EPCOut;
    logic        Req;

    always #5 clk = ~clk;

    cp0 dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .CP0Addr   (CP0Addr),
        .CP0In     (CP0In),
        .VPC       (VPC),
        .BDIn      (BDIn),
        .ExcCodeIn (ExcCodeIn),
        .HWInt     (HWInt),
        .EXLClr    (EXLClr),
        .CP0Out    (CP0Out),
        .EPCOut    (EPCOut),
        .Req       (Req)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state held as architectural 32-bit words.
    logic [31:0] m_sr;
    logic [31:0] m_cause;
    logic [31:0] m_epc;

    vec_t tbl [c_nvec];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    task automatic apply(input in_t x);
        reset     = x.rst_n;
        en        = x.en;
        CP0Addr   = x.addr;
        CP0In     = x.din;
        VPC       = x.vpc;
        BDIn      = x.bd;
        ExcCodeIn = x.exc;
        HWInt     = x.hw;
        EXLClr    = x.exlclr;
    endtask

    function automatic in_t mk_in(input logic rst_n, input logic en_i, input logic [4:0] addr,
                                  input logic [31:0] din, input logic [31:0] vpc, input logic bd,
                                  input logic [4:0] exc, input logic [5:0] hw, input logic exlclr);
        in_t x;
        x.rst_n  = rst_n;
        x.en     = en_i;
        x.addr   = addr;
        x.din    = din;
        x.vpc    = vpc;
        x.bd     = bd;
        x.exc    = exc;
        x.hw     = hw;
        x.exlclr = exlclr;
        return x;
    endfunction

    function automatic vec_t mk(input in_t x, input logic req, input logic [31:0] sr,
                                input logic [31:0] cause, input logic [31:0] epc);
        vec_t v;
        v.i     = x;
        v.req   = req;
        v.sr    = sr;
        v.cause = cause;
        v.epc   = epc;
        return v;
    endfunction

    function automatic logic m_int(input in_t x);
        return ((x.hw & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
    endfunction

    function automatic logic m_req(input in_t x);
        return m_int(x) || ((x.exc != 5'd0) && !m_sr[1]);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] addr);
        case (addr)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return c_prid;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_edge(input in_t x);
        logic        take;
        logic        intr;
        logic [4:0]  code;
        take = m_req(x);
        intr = m_int(x);
        if (!x.rst_n) begin
            m_sr    = 32'd0;
            m_cause = 32'd0;
            m_epc   = 32'd0;
        end else if (take) begin
            code    = intr ? 5'd0 : x.exc;
            m_sr    = m_sr | 32'h2;
            m_cause = {x.bd, 15'd0, x.hw, 3'd0, code, 2'd0};
            m_epc   = x.bd ? x.vpc - 32'd4 : x.vpc;
        end else begin
            m_cause = (m_cause & 32'h8000_007C) | {16'd0, x.hw, 10'd0};
            if (x.en && x.addr == 5'd12) m_sr  = x.din & 32'h0000_FC03;
            if (x.en && x.addr == 5'd14) m_epc = x.din;
            if (x.exlclr)                m_sr  = m_sr & ~32'h2;
        end
    endtask

    task automatic peek_regs(input string tag, input logic [31:0] sr, input logic [31:0] cause,
                             input logic [31:0] epc);
        CP0Addr = 5'd12; #1; check({tag, ".sr"},    CP0Out, sr);
        CP0Addr = 5'd13; #1; check({tag, ".cause"}, CP0Out, cause);
        CP0Addr = 5'd14; #1; check({tag, ".epc"},   CP0Out, epc);
        check({tag, ".epcout"}, EPCOut, epc);
    endtask

    function automatic logic [4:0] pick_exc();
        logic [4:0] codes [9];
        codes = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd4, 5'd5, 5'd8, 5'd10, 5'd12};
        return codes[$urandom_range(0, 8)];
    endfunction

    function automatic logic [4:0] pick_addr();
        int sel;
        sel = int'($urandom_range(0, 7));
        if (sel < 2)  return 5'd12;
        if (sel == 2) return 5'd13;
        if (sel < 5)  return 5'd14;
        if (sel == 5) return 5'd15;
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        in_t idle;
        in_t x;

        //                 rst en addr   din            vpc            bd exc    hw         clr
        tbl[0]  = mk(mk_in(1, 1, 5'd12, 32'h0000_0401, 32'h0,         0, 5'd0,  6'b000000, 0), 0, 32'h0000_0401, 32'h0000_0000, 32'h0000_0000);
        tbl[1]  = mk(mk_in(1, 0, 5'd0,  32'h0,         32'h0000_3000, 0, 5'd0,  6'b000001, 0), 1, 32'h0000_0403, 32'h0000_0400, 32'h0000_3000);
        tbl[2]  = mk(mk_in(1, 0, 5'd0,  32'h0,         32'h0000_3004, 0, 5'd10, 6'b000011, 0), 0, 32'h0000_0403, 32'h0000_0C00, 32'h0000_3000);
        tbl[3]  = mk(mk_in(1, 0, 5'd0,  32'h0,         32'h0000_3008, 0, 5'd0,  6'b000001, 1), 0, 32'h0000_0401, 32'h0000_0400, 32'h0000_3000);
        tbl[4]  = mk(mk_in(1, 0, 5'd0,  32'h0,         32'h0000_3040, 0, 5'd0,  6'b000001, 0), 1, 32'h0000_0403, 32'h0000_0400, 32'h0000_3040);
        tbl[5]  = mk(mk_in(1, 0, 5'd0,  32'h0,         32'h0000_3044, 0, 5'd0,  6'b000000, 1), 0, 32'h0000_0401, 32'h0000_0000, 32'h0000_3040);
        tbl[6]  = mk(mk_in(1, 0, 5'd0,  32'h0,         32'h0000_3008, 1, 5'd12, 6'b000000, 0), 1, 32'h0000_0403, 32'h8000_0030, 32'h0000_3004);
        tbl[7]  = mk(mk_in(1, 1, 5'd12, 32'h0000_0403, 32'h0000_3010, 0, 5'd0,  6'b000000, 1), 0, 32'h0000_0401, 32'h8000_0030, 32'h0000_3004);
        tbl[8]  = mk(mk_in(1, 1, 5'd14, 32'h0000_4180, 32'h0000_3100, 0, 5'd8,  6'b000000, 0), 1, 32'h0000_0403, 32'h0000_0020, 32'h0000_3100);
        tbl[9]  = mk(mk_in(1, 1, 5'd14, 32'h0000_3010, 32'h0000_4000, 0, 5'd0,  6'b000000, 0), 0, 32'h0000_0403, 32'h0000_0020, 32'h0000_3010);
        tbl[10] = mk(mk_in(0, 1, 5'd12, 32'hFFFF_FFFF, 32'h0000_3050, 1, 5'd4,  6'b111111, 1), 0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000);
        tbl[11] = mk(mk_in(1, 0, 5'd0,  32'h0,         32'h0000_0000, 0, 5'd0,  6'b111111, 0), 0, 32'h0000_0000, 32'h0000_FC00, 32'h0000_0000);
        tbl[12] = mk(mk_in(1, 1, 5'd12, 32'hFFFF_FFFF, 32'h0000_0000, 0, 5'd0,  6'b000000, 0), 0, 32'h0000_FC03, 32'h0000_0000, 32'h0000_0000);
        tbl[13] = mk(mk_in(1, 1, 5'd13, 32'hFFFF_FFFF, 32'h0000_0000, 0, 5'd0,  6'b000000, 1), 0, 32'h0000_FC01, 32'h0000_0000, 32'h0000_0000);
        tbl[14] = mk(mk_in(1, 0, 5'd0,  32'h0,         32'h0000_3204, 1, 5'd5,  6'b000100, 0), 1, 32'h0000_FC03, 32'h8000_1000, 32'h0000_3200);

        idle = mk_in(1, 0, 5'd0, 32'h0, 32'h0, 0, 5'd0, 6'd0, 0);

        // Reset state
        x = idle;
        x.rst_n = 1'b0;
        apply(x);
        repeat (2) @(posedge clk);
        #1;
        apply(idle);
        #1;
        check("rst.req", {31'd0, Req}, 32'd0);
        peek_regs("rst", 32'd0, 32'd0, 32'd0);

        // Directed vector table
        for (int i = 0; i < c_nvec; i++) begin
            apply(tbl[i].i);
            @(negedge clk);
            check($sformatf("v%0d.req", i), {31'd0, Req}, {31'd0, tbl[i].req});
            @(posedge clk);
            #1;
            peek_regs($sformatf("v%0d", i), tbl[i].sr, tbl[i].cause, tbl[i].epc);
        end

        // mtc0 EPC while EXL=1: readback shows the old value until the edge
        apply(mk_in(1, 1, 5'd14, 32'hAAAA_AAA8, 32'h0, 0, 5'd0, 6'd0, 0));
        #1;
        check("wr_hidden", CP0Out, 32'h0000_3200);
        @(posedge clk);
        #1;
        check("wr_visible", CP0Out, 32'hAAAA_AAA8);
        check("wr_epcout", EPCOut, 32'hAAAA_AAA8);
        apply(idle);
        CP0Addr = 5'd15; #1; check("prid", CP0Out, c_prid);
        CP0Addr = 5'd3;  #1; check("unimpl3", CP0Out, 32'd0);
        CP0Addr = 5'd31; #1; check("unimpl31", CP0Out, 32'd0);

        // Randomized cycles against the reference model
        x = idle;
        x.rst_n = 1'b0;
        apply(x);
        @(posedge clk);
        model_edge(x);
        #1;
        for (int n = 0; n < c_nrand; n++) begin
            x.rst_n  = ($urandom_range(0, 31) != 0);
            x.en     = 1'($urandom_range(0, 1));
            x.addr   = pick_addr();
            x.din    = $urandom;
            x.vpc    = $urandom & 32'hFFFF_FFFC;
            x.bd     = 1'($urandom_range(0, 1));
            x.exc    = pick_exc();
            x.hw     = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
            x.exlclr = ($urandom_range(0, 3) == 0);
            apply(x);
            @(negedge clk);
            check($sformatf("rnd%0d.req", n), {31'd0, Req}, {31'd0, m_req(x)});
            check($sformatf("rnd%0d.rd", n), CP0Out, m_read(x.addr));
            check($sformatf("rnd%0d.epc", n), EPCOut, m_epc);
            @(posedge clk);
            model_edge(x);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
